// File: rtl/mipu_pkg.sv
// rtl/mipu_pkg.sv - opcode constants and decode helpers for the 16-bit five-stage core
package mipu_pkg;

    localparam logic [15:0] NOP_IR = 16'h0000;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_HALT = 5'b00001;
    localparam logic [4:0] OP_LOAD = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SLA  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_ADD  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_SUB  = 5'b01010;
    localparam logic [4:0] OP_SUBI = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100;
    localparam logic [4:0] OP_AND  = 5'b01101;
    localparam logic [4:0] OP_OR   = 5'b01110;
    localparam logic [4:0] OP_XOR  = 5'b01111;
    localparam logic [4:0] OP_LDIH = 5'b10000;
    localparam logic [4:0] OP_ADDC = 5'b10001;
    localparam logic [4:0] OP_SUBC = 5'b10010;
    localparam logic [4:0] OP_JUMP = 5'b11000;
    localparam logic [4:0] OP_JMPR = 5'b11001;
    localparam logic [4:0] OP_BZ   = 5'b11010;
    localparam logic [4:0] OP_BNZ  = 5'b11011;
    localparam logic [4:0] OP_BN   = 5'b11100;
    localparam logic [4:0] OP_BNN  = 5'b11101;
    localparam logic [4:0] OP_BC   = 5'b11110;
    localparam logic [4:0] OP_BNC  = 5'b11111;

    function automatic logic is_load(input logic [4:0] op);
        return op == OP_LOAD;
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return op == OP_STORE;
    endfunction

    // Three-register ALU forms: A=gr[r2], B=gr[r3]
    function automatic logic is_alu3(input logic [4:0] op);
        return op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic is_shift(input logic [4:0] op);
        return op inside {OP_SLL, OP_SRL, OP_SLA, OP_SRA};
    endfunction

    // Register-relative jump and conditional branches: A=gr[r1], B=v8
    function automatic logic is_branch(input logic [4:0] op);
        return op inside {OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC};
    endfunction

    function automatic logic writes_reg(input logic [4:0] op);
        return op inside {OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI,
                          OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
    endfunction

    function automatic logic uses_r1(input logic [4:0] op);
        return op inside {OP_ADDI, OP_SUBI, OP_LDIH, OP_STORE} || is_branch(op);
    endfunction

    function automatic logic uses_r2(input logic [4:0] op);
        return is_alu3(op) || is_shift(op) || is_load(op) || is_store(op);
    endfunction

    function automatic logic uses_r3(input logic [4:0] op);
        return is_alu3(op);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-source operand forwarding and hazard detect (OPERAND_FORWARDING_EN)
module fwd_select (
    input  logic [2:0]  reg_i,
    input  logic        use_i,
    input  logic [15:0] rf_data_i,
    input  logic [15:0] ex_ir_i,
    input  logic [15:0] ex_result_i,
    input  logic [15:0] mem_ir_i,
    input  logic [15:0] mem_result_i,
    input  logic [15:0] wb_ir_i,
    input  logic [15:0] wb_result_i,
    output logic [15:0] data_o,
    output logic        hazard_o
);
    import mipu_pkg::*;

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic ex_is_load;
    logic unused_bits;

    // A stage only counts as a producer when this source is really read by ID
    always_comb begin
        ex_hit     = use_i && writes_reg(ex_ir_i[15:11])  && (ex_ir_i[10:8]  == reg_i);
        mem_hit    = use_i && writes_reg(mem_ir_i[15:11]) && (mem_ir_i[10:8] == reg_i);
        wb_hit     = use_i && writes_reg(wb_ir_i[15:11])  && (wb_ir_i[10:8]  == reg_i);
        ex_is_load = is_load(ex_ir_i[15:11]);
    end

`ifdef OPERAND_FORWARDING_EN
    assign unused_bits = ^{ex_ir_i[7:0], mem_ir_i[7:0], wb_ir_i[7:0]};

    // Youngest producer wins; a LOAD in EX has no data yet, so it stalls instead
    always_comb begin
        data_o   = rf_data_i;
        hazard_o = ex_hit && ex_is_load;
        if (ex_hit && !ex_is_load) begin
            data_o = ex_result_i;
        end else if (mem_hit) begin
            data_o = mem_result_i;
        end else if (wb_hit) begin
            data_o = wb_result_i;
        end
    end
`else
    assign unused_bits = ^{ex_ir_i[7:0], mem_ir_i[7:0], wb_ir_i[7:0], ex_result_i,
                           mem_result_i, wb_result_i, ex_is_load};

    // Register file only; any in-flight producer holds ID until it has been written back
    always_comb begin
        data_o   = rf_data_i;
        hazard_o = ex_hit || mem_hit || wb_hit;
    end
`endif

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - ID/EX operand stage with hazard stall (forwarding via OPERAND_FORWARDING_EN)
module operand_stage #(
    parameter logic [15:0] NOP_IR = 16'h0000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        flush,
    input  logic [15:0] id_ir,
    output logic [2:0]  rf_addr_a,
    output logic [2:0]  rf_addr_b,
    output logic [2:0]  rf_addr_s,
    input  logic [15:0] rf_data_a,
    input  logic [15:0] rf_data_b,
    input  logic [15:0] rf_data_s,
    input  logic [15:0] ex_alu_o,
    input  logic [15:0] mem_ir,
    input  logic [15:0] mem_result,
    input  logic [15:0] wb_ir,
    input  logic [15:0] wb_result,
    output logic        stall,
    output logic [15:0] ex_ir,
    output logic [15:0] reg_A,
    output logic [15:0] reg_B,
    output logic [15:0] smdr
);
    import mipu_pkg::*;

    logic [4:0]  op;
    logic [2:0]  r1, r2, r3;
    logic [7:0]  v8;
    logic [3:0]  v4;
    logic        use_a, use_b, use_s;
    logic [15:0] fwd_a, fwd_b, fwd_s;
    logic        haz_a, haz_b, haz_s;
    logic [15:0] ex_ir_d, reg_a_d, reg_b_d, smdr_d;
    logic [15:0] ex_ir_q, reg_a_q, reg_b_q, smdr_q;

    assign op = id_ir[15:11];
    assign r1 = id_ir[10:8];
    assign r2 = id_ir[6:4];
    assign r3 = id_ir[2:0];
    assign v8 = id_ir[7:0];
    assign v4 = id_ir[3:0];

    // The A port reads r2 for ALU/shift/memory forms and r1 for immediate/branch forms
    assign use_a     = uses_r2(op) || (uses_r1(op) && !is_store(op));
    assign use_b     = uses_r3(op);
    assign use_s     = is_store(op);
    assign rf_addr_a = uses_r2(op) ? r2 : r1;
    assign rf_addr_b = r3;
    assign rf_addr_s = r1;

    fwd_select u_fwd_a (
        .reg_i(rf_addr_a), .use_i(use_a), .rf_data_i(rf_data_a),
        .ex_ir_i(ex_ir_q), .ex_result_i(ex_alu_o),
        .mem_ir_i(mem_ir), .mem_result_i(mem_result),
        .wb_ir_i(wb_ir), .wb_result_i(wb_result),
        .data_o(fwd_a), .hazard_o(haz_a)
    );

    fwd_select u_fwd_b (
        .reg_i(rf_addr_b), .use_i(use_b), .rf_data_i(rf_data_b),
        .ex_ir_i(ex_ir_q), .ex_result_i(ex_alu_o),
        .mem_ir_i(mem_ir), .mem_result_i(mem_result),
        .wb_ir_i(wb_ir), .wb_result_i(wb_result),
        .data_o(fwd_b), .hazard_o(haz_b)
    );

    fwd_select u_fwd_s (
        .reg_i(rf_addr_s), .use_i(use_s), .rf_data_i(rf_data_s),
        .ex_ir_i(ex_ir_q), .ex_result_i(ex_alu_o),
        .mem_ir_i(mem_ir), .mem_result_i(mem_result),
        .wb_ir_i(wb_ir), .wb_result_i(wb_result),
        .data_o(fwd_s), .hazard_o(haz_s)
    );

    // A squashed or frozen ID instruction must never hold the front end
    assign stall = enable && !flush && (haz_a || haz_b || haz_s);

    // Operand decode, overridden by a bubble on flush or stall
    always_comb begin
        ex_ir_d = id_ir;
        reg_a_d = use_a ? fwd_a : 16'h0000;
        reg_b_d = 16'h0000;
        smdr_d  = use_s ? fwd_s : 16'h0000;
        if (is_alu3(op)) begin
            reg_b_d = fwd_b;
        end else if (op == OP_LDIH) begin
            reg_b_d = {v8, 8'h00};
        end else if (is_shift(op) || is_load(op) || is_store(op)) begin
            reg_b_d = {12'h000, v4};
        end else if (op == OP_ADDI || op == OP_SUBI || op == OP_JUMP || is_branch(op)) begin
            reg_b_d = {8'h00, v8};
        end
        if (flush || stall) begin
            ex_ir_d = NOP_IR;
            reg_a_d = 16'h0000;
            reg_b_d = 16'h0000;
            smdr_d  = 16'h0000;
        end
    end

    // ID/EX pipeline register, frozen while the CPU is not running
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ex_ir_q <= NOP_IR;
            reg_a_q <= 16'h0000;
            reg_b_q <= 16'h0000;
            smdr_q  <= 16'h0000;
        end else if (enable) begin
            ex_ir_q <= ex_ir_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            smdr_q  <= smdr_d;
        end
    end

    assign ex_ir = ex_ir_q;
    assign reg_A = reg_a_q;
    assign reg_B = reg_b_q;
    assign smdr  = smdr_q;

endmodule

// File: doc/operand_stage.md
# operand_stage

ID/EX pipeline stage of the 16-bit five-stage core. It takes the instruction held in the IF/ID register and reads the register file. It resolves data hazards by forwarding, or by stalling on a load-use hazard. It then registers `ex_ir`, `reg_A`, `reg_B` and `smdr`, which are the operands the EX-stage ALU consumes, and it drives the stall and bubble behaviour of the front end.

## Interface
Parameters:
- `NOP_IR`, default 16'h0000: the bubble instruction (opcode 5'b00000).

Ports:
- `clock`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  CPU run state. When low, all registers hold their value.
- `flush`  in  1  taken branch/jump resolved downstream. Squashes the instruction in ID.
- `id_ir`  in  16  instruction in ID.
- `rf_addr_a`, `rf_addr_b`, `rf_addr_s`  out  3 each  register-file read addresses, decoded combinationally from `id_ir`.
- `rf_data_a`, `rf_data_b`, `rf_data_s`  in  16 each  register-file read data.
- `ex_alu_o`  in  16  ALU result of the instruction currently in EX.
- `mem_ir`, `mem_result`  in  16 each  MEM-stage instruction and its result.
- `wb_ir`, `wb_result`  in  16 each  WB-stage instruction and its result.
- `stall`  out  1  combinational. While high, IF and IF/ID hold.
- `ex_ir`, `reg_A`, `reg_B`, `smdr`  out  16 each  registered outputs to EX.

## Operation
- Fields: `op=ir[15:11]`, `r1=ir[10:8]`, `r2=ir[6:4]`, `r3=ir[2:0]`, `v8=ir[7:0]`, `v4=ir[3:0]`.
- Operand selection:
  - ADD/ADDC/SUB/SUBC/CMP/AND/OR/XOR: A=gr[r2], B=gr[r3].
  - ADDI/SUBI: A=gr[r1], B={8'b0,v8}.
  - LDIH: A=gr[r1], B={v8,8'b0}.
  - SLL/SRL/SLA/SRA and LOAD: A=gr[r2], B={12'b0,v4}.
  - STORE: A=gr[r2], B={12'b0,v4}, smdr=gr[r1].
  - JUMP: A=0, B={8'b0,v8}.
  - JMPR/BZ/BNZ/BN/BNN/BC/BNC: A=gr[r1], B={8'b0,v8}.
  - All other opcodes: A=B=smdr=0.
  - smdr is 0 for every non-STORE instruction.
- Register writers: LOAD, LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SRL, SLA, SRA. The destination is r1. gr0 is an ordinary register.
- Source match: a source register matches a writer's destination only if that source is actually used by the instruction in ID.
- Forwarding priority for each used source, first match wins:
  1. EX (`ex_ir` is a non-LOAD writer): use `ex_alu_o`.
  2. MEM: use `mem_result`.
  3. WB: use `wb_result`.
  4. Otherwise use the register-file data.
- Load-use stall: `ex_ir` is LOAD and its destination matches a used source of `id_ir`. The stall lasts exactly one cycle.
- Update priority on each rising edge while `enable` is high:
  1. `flush`: load a bubble.
  2. `stall`: load a bubble.
  3. Otherwise load the decoded `id_ir` and its operands.
- Bubble: `ex_ir`=NOP_IR, `reg_A`=`reg_B`=`smdr`=0.
- `stall` is forced to 0 when `flush` or `!enable`.

## Timing
- Reset (async assert, sync release): `ex_ir`=NOP_IR, `reg_A`=`reg_B`=`smdr`=0. `stall` reads 0 because `ex_ir` is then NOP.
- Latency: one cycle from `id_ir` to `ex_ir`/`reg_A`/`reg_B`/`smdr`.
- Load-use: the cycle after the stall, the LOAD is in MEM and the value is forwarded from `mem_result`.
- Simultaneous `flush` and hazard: bubble inserted and `stall`=0. The squashed ID instruction is never stalled.
- Reset mid-stall: all outputs return to reset values immediately. No stall state persists, because stall is purely combinational from `ex_ir`/`id_ir`.

## Configuration
- `OPERAND_FORWARDING_EN` defined:
  - Forwarding as described above.
  - Only load-use hazards stall.
- `OPERAND_FORWARDING_EN` undefined:
  - No forwarding paths; operands come from the register file only.
  - `stall` is asserted while any used source matches the destination of a writer in EX, MEM or WB. The register file writes at the clock edge.
  - A dependent instruction therefore stalls up to three cycles.

## Structure
- Shared package `mipu_pkg`:
  - opcode constants and NOP_IR;
  - functions `writes_reg(op)`, `uses_r1/uses_r2/uses_r3(op)`, `is_load(op)`.
- Sub-module `fwd_select`: instantiated three times (A-source, B-source, smdr-source). It takes a register number, a use flag, the register-file data and the three stage ir/result pairs. It outputs the forwarded value and a load-hazard bit.

## Test plan
- Reset with `rst_n`=0 mid-run → all outputs 0 / NOP_IR. Then ADD gr3,gr1,gr2 with gr1=5, gr2=7 → next cycle `reg_A`=5, `reg_B`=7.
- ADD gr1,… with EX `ex_alu_o`=16'h00AA, followed by SUB using r2=gr1 → `reg_A`=16'h00AA (EX forward). The same hazard with the writer in MEM (result 16'h0011) → `reg_A`=16'h0011.
- Back-to-back dependency: writer in EX `ex_alu_o`=1, another writer to the same register in MEM `mem_result`=2 → 1 is selected.
- LOAD gr2 in EX, ADDI gr2,#3 in ID → `stall`=1 for one cycle and bubble in EX. Next cycle `reg_A`=`mem_result`, `reg_B`=3.
- STORE gr4,gr5,#2 with gr4=16'hBEEF, gr5=16'h0100 → `reg_A`=16'h0100, `reg_B`=2, `smdr`=16'hBEEF.
- `flush`=1 during a load-use hazard → `stall`=0 and bubble loaded. `enable`=0 → outputs hold for 3 cycles.
